// File: rtl/cv32e40x_instr_obi_adapter.sv
// Prefetcher-to-OBI instruction bus adapter: holds address phase until gnt, tags and filters responses.
// Optional macro CV32E40X_FETCH_ADDR_ALIGN_EN forces word-aligned bus addresses.
module cv32e40x_instr_obi_adapter #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trans_valid_i,
  output logic        trans_ready_o,
  input  logic [31:0] trans_addr_i,
  input  logic        trans_ptr_i,
  input  logic [1:0]  trans_priv_i,
  input  logic        kill_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        resp_ptr_o,
  output logic        busy_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  output logic [2:0]  instr_prot_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned DW = CW + 1;

  typedef enum logic {TRANSPARENT = 1'b0, REGISTERED = 1'b1} state_e;

  state_e                     state_q;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [DW-1:0]              drop_q, drop_d;
  logic [31:0]                addr_q;
  logic [2:0]                 prot_q;
  logic                       ptr_q;
  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;

  logic [31:0]   transAddr;
  logic          isReg;
  logic          accept;
  logic          grant;
  logic          pushPtr;
  logic [CW-1:0] pushIdx;

`ifdef CV32E40X_FETCH_ADDR_ALIGN_EN
  assign transAddr = {trans_addr_i[31:2], 2'b00};
`else
  assign transAddr = trans_addr_i;
`endif

  assign isReg         = (state_q == REGISTERED);
  assign trans_ready_o = !isReg && !kill_i && (cnt_q < CW'(MAX_OUTSTANDING));
  assign accept        = trans_valid_i && trans_ready_o;
  assign instr_req_o   = isReg || accept;
  assign instr_addr_o  = isReg ? addr_q : transAddr;
  assign instr_prot_o  = isReg ? prot_q : {trans_priv_i, 1'b0};
  assign grant         = instr_req_o && instr_gnt_i;
  assign pushPtr       = isReg ? ptr_q : trans_ptr_i;

  assign resp_valid_o  = instr_rvalid_i && (drop_q == '0) && !kill_i;
  assign resp_rdata_o  = instr_rdata_i;
  assign resp_err_o    = instr_err_i;
  assign resp_ptr_o    = fifo_q[0];
  assign busy_o        = (cnt_q != '0) || isReg;

  // FIFO occupancy equals cnt_q, so the push slot is the current fill level after any pop.
  always_comb begin
    cnt_d   = cnt_q;
    fifo_d  = fifo_q;
    pushIdx = cnt_q - CW'(instr_rvalid_i);
    if (grant && !instr_rvalid_i) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!grant && instr_rvalid_i && cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
    if (instr_rvalid_i) begin
      fifo_d = fifo_q >> 1;
    end
    if (grant) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        if (pushIdx == CW'(i)) fifo_d[i] = pushPtr;
      end
    end
  end

  // A kill drops everything granted or about to be granted, less the response retiring now.
  always_comb begin
    drop_d = drop_q;
    if (kill_i) begin
      drop_d = {1'b0, cnt_q} + DW'(isReg);
      if (instr_rvalid_i && drop_d != '0) drop_d = drop_d - DW'(1);
    end else if (instr_rvalid_i && drop_q != '0) begin
      drop_d = drop_q - DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TRANSPARENT;
      cnt_q   <= '0;
      drop_q  <= '0;
      addr_q  <= '0;
      prot_q  <= '0;
      ptr_q   <= 1'b0;
      fifo_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
      fifo_q <= fifo_d;
      case (state_q)
        TRANSPARENT: begin
          if (accept && !instr_gnt_i) begin
            state_q <= REGISTERED;
            addr_q  <= transAddr;
            prot_q  <= {trans_priv_i, 1'b0};
            ptr_q   <= trans_ptr_i;
          end
        end
        REGISTERED: begin
          if (instr_gnt_i) state_q <= TRANSPARENT;
        end
        default: state_q <= TRANSPARENT;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (rst) instr_rvalid_i |-> (cnt_q != '0));

  assert property (@(posedge clk) disable iff (rst)
    (isReg && !instr_gnt_i) |=> ($stable(instr_addr_o) && $stable(instr_prot_o)));

endmodule

// File: tb/tb_cv32e40x_instr_obi_adapter.sv
// Self-checking bench for cv32e40x_instr_obi_adapter: directed scenarios then random traffic,
// checked against a transaction-queue model of the adapter.
module tb_cv32e40x_instr_obi_adapter;

  localparam int MAX = 2;

  logic        clk;
  logic        rst;
  logic        trans_valid_i;
  logic        trans_ready_o;
  logic [31:0] trans_addr_i;
  logic        trans_ptr_i;
  logic [1:0]  trans_priv_i;
  logic        kill_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        resp_ptr_o;
  logic        busy_o;
  logic        instr_req_o;
  logic        instr_gnt_i;
  logic [31:0] instr_addr_o;
  logic [2:0]  instr_prot_o;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;

  cv32e40x_instr_obi_adapter #(.MAX_OUTSTANDING(MAX)) dut (
    .clk            (clk),
    .rst            (rst),
    .trans_valid_i  (trans_valid_i),
    .trans_ready_o  (trans_ready_o),
    .trans_addr_i   (trans_addr_i),
    .trans_ptr_i    (trans_ptr_i),
    .trans_priv_i   (trans_priv_i),
    .kill_i         (kill_i),
    .resp_valid_o   (resp_valid_o),
    .resp_rdata_o   (resp_rdata_o),
    .resp_err_o     (resp_err_o),
    .resp_ptr_o     (resp_ptr_o),
    .busy_o         (busy_o),
    .instr_req_o    (instr_req_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_addr_o   (instr_addr_o),
    .instr_prot_o   (instr_prot_o),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        ptr;
    logic        killed;
  } txn_t;

  // Model: granted transactions awaiting a response, oldest first, plus at most one ungranted request.
  txn_t        outQ[$];
  txn_t        pend;
  logic [2:0]  pendProt;
  logic        pendValid;
  logic        expReqM;
  logic        expAcceptM;

  int vectors;
  int miscompares;

  function automatic logic [31:0] alignAddr(input logic [31:0] a);
`ifdef CV32E40X_FETCH_ADDR_ALIGN_EN
    return {a[31:2], 2'b00};
`else
    return a;
`endif
  endfunction

  task automatic checkSig(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow from the model state and the inputs applied this cycle.
  task automatic checkOutput();
    logic expReady;
    logic expRespValid;
    txn_t head;
    expReady   = !pendValid && !kill_i && (outQ.size() < MAX);
    expAcceptM = trans_valid_i && expReady;
    expReqM    = pendValid || expAcceptM;
    checkSig("trans_ready", 32'(trans_ready_o), 32'(expReady));
    checkSig("instr_req", 32'(instr_req_o), 32'(expReqM));
    checkSig("busy", 32'(busy_o), 32'((outQ.size() != 0) || pendValid));
    if (expReqM) begin
      checkSig("instr_addr", instr_addr_o, pendValid ? pend.addr : alignAddr(trans_addr_i));
      checkSig("instr_prot", 32'(instr_prot_o), 32'(pendValid ? pendProt : {trans_priv_i, 1'b0}));
    end
    if (instr_rvalid_i) begin
      head         = outQ[0];
      expRespValid = !head.killed && !kill_i;
      checkSig("resp_valid", 32'(resp_valid_o), 32'(expRespValid));
      checkSig("resp_ptr", 32'(resp_ptr_o), 32'(head.ptr));
      checkSig("resp_rdata", resp_rdata_o, instr_rdata_i);
      checkSig("resp_err", 32'(resp_err_o), 32'(instr_err_i));
    end else begin
      checkSig("resp_valid_idle", 32'(resp_valid_o), 32'b0);
    end
  endtask

  task automatic updateModel();
    txn_t nt;
    nt.addr   = alignAddr(trans_addr_i);
    nt.ptr    = trans_ptr_i;
    nt.killed = 1'b0;
    if (instr_rvalid_i) void'(outQ.pop_front());
    if (kill_i) begin
      foreach (outQ[i]) outQ[i].killed = 1'b1;
      if (pendValid) pend.killed = 1'b1;
    end
    if (expReqM && instr_gnt_i) begin
      if (pendValid) begin
        outQ.push_back(pend);
        pendValid = 1'b0;
      end else begin
        outQ.push_back(nt);
      end
    end else if (expAcceptM) begin
      pend      = nt;
      pendProt  = {trans_priv_i, 1'b0};
      pendValid = 1'b1;
    end
  endtask

  // One bus cycle: drive inputs just after the edge, check before the next edge, advance the model.
  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic p,
                               input logic [1:0] pr, input logic k, input logic g,
                               input logic rv, input logic e);
    @(posedge clk);
    #1;
    trans_valid_i  = v;
    trans_addr_i   = a;
    trans_ptr_i    = p;
    trans_priv_i   = pr;
    kill_i         = k;
    instr_gnt_i    = g;
    instr_rvalid_i = rv && (outQ.size() != 0);
    instr_rdata_i  = $urandom;
    instr_err_i    = e;
    #3;
    checkOutput();
    updateModel();
  endtask

  task automatic clearInputs();
    trans_valid_i  = 1'b0;
    trans_addr_i   = '0;
    trans_ptr_i    = 1'b0;
    trans_priv_i   = '0;
    kill_i         = 1'b0;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    instr_err_i    = 1'b0;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    clearInputs();
    outQ.delete();
    pendValid = 1'b0;
    #3;
    checkSig("rst_trans_ready", 32'(trans_ready_o), 32'b1);
    checkSig("rst_instr_req", 32'(instr_req_o), 32'b0);
    checkSig("rst_busy", 32'(busy_o), 32'b0);
    checkSig("rst_resp_valid", 32'(resp_valid_o), 32'b0);
    checkSig("rst_resp_ptr", 32'(resp_ptr_o), 32'b0);
    checkSig("rst_instr_addr", instr_addr_o, 32'h0);
    checkSig("rst_instr_prot", 32'(instr_prot_o), 32'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((outQ.size() != 0 || pendValid) && n < 20) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
      n++;
    end
    checkSig("drain_done", 32'((outQ.size() != 0) || pendValid), 32'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    pendValid   = 1'b0;
    rst         = 1'b1;
    clearInputs();
    doReset();

    $display("[TB] back-to-back accept");
    applyStimulus(1'b1, 32'h100, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h104, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h108, 1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
    checkSig("b2b_third_blocked", 32'(trans_ready_o), 32'b0);
    applyStimulus(1'b0, 32'h108, 1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
    drain();

    $display("[TB] stalled grant");
    applyStimulus(1'b1, 32'h200, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h300, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    checkSig("stall_addr_held", instr_addr_o, 32'h200);
    applyStimulus(1'b1, 32'h300, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    checkSig("stall_addr_kill", instr_addr_o, 32'h200);
    applyStimulus(1'b0, 32'h300, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    drain();

    $display("[TB] kill with outstanding plus pending");
    applyStimulus(1'b1, 32'h380, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h390, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    checkSig("kill_drop1", 32'(resp_valid_o), 32'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    checkSig("kill_drop2", 32'(resp_valid_o), 32'b0);
    applyStimulus(1'b1, 32'h400, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    checkSig("kill_after_deliver", 32'(resp_valid_o), 32'b1);

    $display("[TB] kill coincident with rvalid");
    applyStimulus(1'b1, 32'h480, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h484, 1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    checkSig("killrv_resp", 32'(resp_valid_o), 32'b0);
    applyStimulus(1'b1, 32'h490, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    checkSig("killrv_ready", 32'(trans_ready_o), 32'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    checkSig("killrv_deliver", 32'(resp_valid_o), 32'b1);

    $display("[TB] pointer tagging");
    applyStimulus(1'b1, 32'h500, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h504, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    checkSig("ptr_first", 32'(resp_ptr_o), 32'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
    checkSig("ptr_second", 32'(resp_ptr_o), 32'b0);
    checkSig("err_second", 32'(resp_err_o), 32'b1);

    $display("[TB] alignment");
    applyStimulus(1'b1, 32'h602, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef CV32E40X_FETCH_ADDR_ALIGN_EN
    checkSig("align_addr", instr_addr_o, 32'h600);
`else
    checkSig("align_addr", instr_addr_o, 32'h602);
`endif
    applyStimulus(1'b1, 32'h606, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef CV32E40X_FETCH_ADDR_ALIGN_EN
    checkSig("align_latched", instr_addr_o, 32'h604);
`else
    checkSig("align_latched", instr_addr_o, 32'h606);
`endif
    drain();

    $display("[TB] reset mid-transaction");
    applyStimulus(1'b1, 32'h700, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h704, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    doReset();

    $display("[TB] random traffic");
    for (int n = 0; n < 2000; n++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom), 2'($urandom),
                    1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0),
                    1'($urandom), 1'($urandom_range(0, 7) == 0));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
